// File: rtl/pc_sequencer_if.sv
// Next-PC control bundle between the pipeline (master) and the PC sequencer (slave).
// Carries the current PC, the hazard/redirect requests and the resulting fetch controls.
interface pc_sequencer_if;
   logic [31:0] pc;
   logic        stall_req;
   logic        redirect_req;
   logic [31:0] redirect_target;
   logic        trap_req;
   logic        halt_req;
   logic        resume;
   logic [31:0] pc_next;
   logic        stall_if_id;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        halted;
   logic        misalign_err;
   logic [15:0] redirect_count;

   modport master (
      output pc, stall_req, redirect_req, redirect_target, trap_req, halt_req, resume,
      input  pc_next, stall_if_id, flush_if_id, flush_id_ex, halted, misalign_err,
             redirect_count
   );

   modport slave (
      input  pc, stall_req, redirect_req, redirect_target, trap_req, halt_req, resume,
      output pc_next, stall_if_id, flush_if_id, flush_id_ex, halted, misalign_err,
             redirect_count
   );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: arbitrates sequential fetch, EX redirects, traps, halt and
// load-use stalls, and holds fetch at RESET_PC for a boot interval after reset.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
   parameter int unsigned BOOT_CYCLES = 4
) (
   input logic            clk,
   input logic            rst,
   pc_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

   localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

   state_t      state_p1, state_nx;
   logic [7:0]  boot_cnt_p1;
   logic [15:0] count_p1;
   logic        misalign_p1;
   logic        halted_p1;

   logic        in_run, misaligned;
   logic        take_trap, take_redir, take_halt, take_stall;
   logic [31:0] pc_next;
   logic        stall_if_id, flush_if_id, flush_id_ex;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // A misaligned redirect is folded into the trap path so it shares its priority slot.
   always_comb begin
      in_run     = rst && (state_p1 == RUN);
      misaligned = bus.redirect_req && (bus.redirect_target[1:0] != 2'b00);
      take_trap  = in_run && (bus.trap_req || misaligned);
      take_redir = in_run && !bus.trap_req && bus.redirect_req && !misaligned;
      take_halt  = in_run && !bus.trap_req && !bus.redirect_req && bus.halt_req;
      take_stall = in_run && !bus.trap_req && !bus.redirect_req && !bus.halt_req &&
                   bus.stall_req;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_p1    <= BOOT;
         boot_cnt_p1 <= 8'd0;
         count_p1    <= 16'd0;
         misalign_p1 <= 1'b0;
         halted_p1   <= 1'b0;
      end else begin
         state_p1    <= state_nx;
         boot_cnt_p1 <= (state_p1 == BOOT && state_nx == BOOT) ? boot_cnt_p1 + 8'd1 : 8'd0;
         count_p1    <= (take_trap || take_redir) ? sat_inc(count_p1) : count_p1;
         misalign_p1 <= in_run && !bus.trap_req && misaligned;
         halted_p1   <= (state_nx == HALT);
      end
   end

   always_comb begin
      state_nx = state_p1;
      case (state_p1)
         BOOT:    if (boot_cnt_p1 == BOOT_LAST) state_nx = RUN;
         RUN:     if (take_halt) state_nx = HALT;
         HALT:    if (bus.resume) state_nx = RUN;
         default: state_nx = BOOT;
      endcase
   end

   always_comb begin
      pc_next     = bus.pc + 32'd4;
      stall_if_id = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      if (!rst || (state_p1 != RUN && state_p1 != HALT)) begin
         pc_next     = RESET_PC;
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (state_p1 == HALT) begin
         pc_next     = bus.pc;
         flush_if_id = 1'b1;
      end else if (take_trap) begin
         pc_next     = TRAP_VEC;
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (take_redir) begin
         pc_next     = bus.redirect_target;
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (take_halt) begin
         pc_next     = bus.pc;
         flush_if_id = 1'b1;
      end else if (take_stall) begin
         pc_next     = bus.pc;
         stall_if_id = 1'b1;
      end
   end

   assign bus.pc_next        = pc_next;
   assign bus.stall_if_id    = stall_if_id;
   assign bus.flush_if_id    = flush_if_id;
   assign bus.flush_id_ex    = flush_id_ex;
   assign bus.halted         = halted_p1;
   assign bus.misalign_err   = misalign_p1;
   assign bus.redirect_count = count_p1;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the five-stage RISC-V pipeline.
- Drives the PC register's next-value input and arbitrates between sequential fetch, EX-stage branch/jump redirects, traps, halts and load-use stalls.
- Generates the IF/ID stall and IF/ID, ID/EX flush controls.
- Holds fetch for a boot interval after reset.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address used during reset and boot.
- TRAP_VEC, 32'h0000_0100, target for trap and misaligned-redirect.
- BOOT_CYCLES, 4, cycles fetch is held after reset release (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- pc  in  32  current PC from the PC register.
- stall_req  in  1  load-use hazard from the hazard unit.
- redirect_req  in  1  taken branch or jump resolved in EX.
- redirect_target  in  32  EX-computed target.
- trap_req  in  1  exception or ecall from EX.
- halt_req  in  1  ebreak or halt from EX.
- resume  in  1  leave HALT.
- pc_next  out  32  value loaded into the PC register each edge.
- stall_if_id  out  1  hold the IF/ID register.
- flush_if_id  out  1  bubble the IF/ID register.
- flush_id_ex  out  1  bubble the ID/EX register.
- halted  out  1  high while in HALT.
- misalign_err  out  1  one-cycle pulse when a redirect target has bits[1:0] != 0.
- redirect_count  out  16  saturating count of applied redirects and traps.

Behaviour:
- **State machine:** three states, BOOT, RUN and HALT, held in a registered state plus an 8-bit boot counter. pc_next, stall and flush outputs are combinational from state and inputs. halted, misalign_err and redirect_count are registered.
- **Reset** (rst=0 at an edge):
  - state := BOOT, boot counter := 0, redirect_count := 0, misalign_err := 0, halted := 0.
  - While rst=0: pc_next = RESET_PC, flush_if_id = flush_id_ex = 1, stall_if_id = 0.
  - Reset mid-operation overrides all requests.
- **BOOT:**
  - pc_next = RESET_PC, both flushes = 1, all requests ignored.
  - Counter increments each cycle. When the counter reaches BOOT_CYCLES-1, state := RUN.
  - The first RUN cycle therefore sees pc = RESET_PC and fetches it.
- **RUN:** fixed priority, highest first.
  1. trap_req: pc_next = TRAP_VEC, flush_if_id = flush_id_ex = 1, count += 1.
  2. redirect_req with target[1:0]==0: pc_next = redirect_target, both flushes = 1, count += 1.
  3. redirect_req with target[1:0]!=0: treated exactly as a trap (pc_next = TRAP_VEC, both flushes, count += 1), and misalign_err = 1 in the next cycle.
  4. halt_req: pc_next = pc, flush_if_id = 1, flush_id_ex = 0, state := HALT.
  5. stall_req: pc_next = pc, stall_if_id = 1, no flush.
  6. Otherwise: pc_next = pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- **Redirect latency:** a request sampled at edge N gives PC = target after edge N+1 — one cycle.
- **Redirect beats stall:** when redirect and stall are asserted together, stall_if_id = 0 and the flushes win.
- **HALT:**
  - pc_next = pc, flush_if_id = 1, halted = 1.
  - trap_req, redirect_req, halt_req and stall_req are ignored.
  - resume=1: state := RUN; the following cycle fetches the held pc, i.e. pc_next resumes as pc + 4 after that fetch.
- **redirect_count:** saturates at 16'hFFFF.
- **misalign_err:** deasserts after one cycle unless retriggered.

Test Plan:
- Reset held 3 cycles, then released with BOOT_CYCLES=4 -> pc_next=0 and both flushes high for 4 cycles; then pc sequence 0,4,8,C.
- At pc=0x20, redirect_req=1 with target 0x80 -> after the next edge pc=0x80, flush_if_id=flush_id_ex=1 in the request cycle, redirect_count=1.
- stall_req high 2 cycles at pc=0x40 -> pc stays 0x40 for 2 edges, stall_if_id=1, no flush; then pc=0x44.
- redirect_req with target 0x82, trap_req and stall_req all asserted in the same cycle -> pc=0x100, misalign_err not asserted (trap wins), count += 1. Repeat with only redirect to 0x82 -> pc=0x100, misalign_err pulse one cycle.
- halt_req at pc=0x50 -> halted=1, pc holds 0x50 while a redirect is asserted; resume -> pc continues 0x50, then 0x54.
- Force redirect_count to 0xFFFE and apply 3 redirects -> count stays 0xFFFF. Assert rst low mid-HALT -> state BOOT, halted=0, count=0.
